// File: rtl/adc_avg_bcd_pkg.sv
// Shared constants for the ADC averaging / millivolt BCD path: FSM state
// encoding, data widths and the double-dabble iteration count.
package adc_avg_bcd_pkg;

    localparam int ADC_BITS   = 12;
    localparam int BCD_DIGITS = 4;
    localparam int CONV_ITERS = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/adc_avg_bcd_bin2bcd_seq.sv
// Sequential double-dabble: loads bin on start, then performs one
// add-3/shift step per cycle for CONV_ITERS cycles.
module bin2bcd_seq
    import adc_avg_bcd_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADC_BITS-1:0]     bin,
    output logic                    done,
    output logic [4*BCD_DIGITS-1:0] bcd
);

    localparam int SR_W = 4 * BCD_DIGITS + ADC_BITS;

    logic [SR_W-1:0] shift_reg;
    logic [SR_W-1:0] shift_adj;
    logic [3:0]      iter_reg;
    logic            busy_reg;
    logic            last_iter;

    assign shift_adj[ADC_BITS-1:0] = shift_reg[ADC_BITS-1:0];

    generate
        for (genvar gi = 0; gi < BCD_DIGITS; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = shift_reg[ADC_BITS + 4*gi +: 4];
            assign shift_adj[ADC_BITS + 4*gi +: 4] = (digit >= 4'd5) ? digit + 4'd3 : digit;
        end
    endgenerate

    // High in the cycle whose closing edge performs the final iteration.
    assign last_iter = busy_reg && (iter_reg == 4'(CONV_ITERS - 1));
    assign done      = last_iter;
    assign bcd       = shift_reg[SR_W-1 -: 4*BCD_DIGITS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg <= '0;
            iter_reg  <= '0;
            busy_reg  <= 1'b0;
        end else if (start) begin
            shift_reg <= {{(4*BCD_DIGITS){1'b0}}, bin};
            iter_reg  <= '0;
            busy_reg  <= 1'b1;
        end else if (busy_reg) begin
            shift_reg <= shift_adj << 1;
            iter_reg  <= iter_reg + 4'd1;
            if (last_iter)
                busy_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/adc_avg_bcd.sv
// Windowed ADC average -> millivolts -> packed BCD, tagged with channel.
// ADC_AVG_ROUND_EN selects round-half-up at both divisions (default: truncate).
module adc_avg_bcd
    import adc_avg_bcd_pkg::*;
#(
    parameter int AVG_LOG2 = 4,
    parameter int VREF_MV  = 3300
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] adc_data,
    input  logic        adc_busy,
    input  logic [2:0]  addr,
    output logic [15:0] mv_bcd,
    output logic [11:0] mv_bin,
    output logic [2:0]  ch_out,
    output logic        valid
);

    localparam int          ACC_W  = ADC_BITS + AVG_LOG2;
    localparam logic [11:0] VREF_L = VREF_MV[11:0];

`ifdef ADC_AVG_ROUND_EN
    localparam logic [ACC_W:0] AVG_RND = (ACC_W+1)'(1) << (AVG_LOG2 - 1);
    localparam logic [24:0]    MV_RND  = 25'd2048;
`else
    localparam logic [ACC_W:0] AVG_RND = '0;
    localparam logic [24:0]    MV_RND  = '0;
`endif

    logic                busy_d_reg;
    logic [2:0]          addr_q_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [AVG_LOG2-1:0] count_reg;
    logic [11:0]         avg_reg;
    logic [2:0]          ch_reg;
    logic [1:0]          state_reg;
    logic [11:0]         mv_reg;
    logic [15:0]         mv_bcd_reg;
    logic [11:0]         mv_bin_reg;
    logic [2:0]          ch_out_reg;
    logic                valid_reg;

    logic                capture;
    logic                ch_change;
    logic                window_last;
    logic [ACC_W:0]      sum_full;
    logic [11:0]         avg_next;
    logic [24:0]         product;
    logic [24:0]         mv_scaled;
    logic [11:0]         mv_next;
    logic                conv_done;
    logic [15:0]         conv_bcd;

    assign capture     = busy_d_reg && !adc_busy;
    assign ch_change   = (addr != addr_q_reg);
    assign window_last = capture && !ch_change && (count_reg == '1);

    assign sum_full  = {1'b0, acc_reg} + {{(AVG_LOG2+1){1'b0}}, adc_data} + AVG_RND;
    assign avg_next  = 12'(sum_full >> AVG_LOG2);

    assign product   = {13'd0, avg_reg} * {13'd0, VREF_L} + MV_RND;
    assign mv_scaled = product >> 12;
`ifdef ADC_AVG_ROUND_EN
    assign mv_next   = (mv_scaled > 25'd4095) ? 12'hFFF : 12'(mv_scaled);
`else
    assign mv_next   = 12'(mv_scaled);
`endif

    // Accumulation never stalls; only the avg/channel latch is gated by IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_d_reg <= 1'b0;
            addr_q_reg <= '0;
            acc_reg    <= '0;
            count_reg  <= '0;
            avg_reg    <= '0;
            ch_reg     <= '0;
        end else begin
            busy_d_reg <= adc_busy;
            addr_q_reg <= addr;
            if (ch_change) begin
                acc_reg   <= '0;
                count_reg <= '0;
            end else if (capture) begin
                if (count_reg == '1) begin
                    acc_reg   <= '0;
                    count_reg <= '0;
                    if (state_reg == ST_IDLE) begin
                        avg_reg <= avg_next;
                        ch_reg  <= addr_q_reg;
                    end
                end else begin
                    acc_reg   <= acc_reg + {{AVG_LOG2{1'b0}}, adc_data};
                    count_reg <= count_reg + AVG_LOG2'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            mv_reg     <= '0;
            mv_bcd_reg <= '0;
            mv_bin_reg <= '0;
            ch_out_reg <= '0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: if (window_last) state_reg <= ST_MUL;
                ST_MUL: begin
                    mv_reg    <= mv_next;
                    state_reg <= ST_CONV;
                end
                ST_CONV: if (conv_done) state_reg <= ST_DONE;
                ST_DONE: begin
                    mv_bcd_reg <= conv_bcd;
                    mv_bin_reg <= mv_reg;
                    ch_out_reg <= ch_reg;
                    valid_reg  <= 1'b1;
                    state_reg  <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (state_reg == ST_MUL),
        .bin   (mv_next),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign mv_bcd = mv_bcd_reg;
    assign mv_bin = mv_bin_reg;
    assign ch_out = ch_out_reg;
    assign valid  = valid_reg;

endmodule

// File: tb/tb_adc_avg_bcd.sv
// Bench for adc_avg_bcd: table-driven windows with a result scoreboard, plus
// channel-change, reset-abort and overrun sequences (overrun on a 2-sample DUT).
module tb_adc_avg_bcd;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] adc_data, adc_data2;
    logic        adc_busy, adc_busy2;
    logic [2:0]  addr, addr2;
    logic [15:0] mv_bcd, mv_bcd2;
    logic [11:0] mv_bin, mv_bin2;
    logic [2:0]  ch_out, ch_out2;
    logic        valid, valid2;

    adc_avg_bcd u_dut (
        .clk(clk), .rst(rst), .adc_data(adc_data), .adc_busy(adc_busy), .addr(addr),
        .mv_bcd(mv_bcd), .mv_bin(mv_bin), .ch_out(ch_out), .valid(valid)
    );

    adc_avg_bcd #(.AVG_LOG2(1), .VREF_MV(3300)) u_dut2 (
        .clk(clk), .rst(rst), .adc_data(adc_data2), .adc_busy(adc_busy2), .addr(addr2),
        .mv_bcd(mv_bcd2), .mv_bin(mv_bin2), .ch_out(ch_out2), .valid(valid2)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [11:0] bin;
        logic [2:0]  ch;
        int          t_cap;
    } exp_t;

    typedef struct {
        logic [11:0] v1;
        logic [11:0] v2;
        logic [2:0]  ch;
        logic [15:0] bcd;
        logic [11:0] bin;
    } vec_t;

    exp_t sb_q[$];
    exp_t mon_e;
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int valid2_cnt = 0;
    int n_expected = 0;
    logic prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [11:0] model_mv(input int sum);
        int avg, mv;
`ifdef ADC_AVG_ROUND_EN
        avg = (sum + 8) / 16;
        mv  = (avg * 3300 + 2048) / 4096;
        if (mv > 4095) mv = 4095;
`else
        avg = sum / 16;
        mv  = (avg * 3300) / 4096;
`endif
        return mv[11:0];
    endfunction

    function automatic logic [15:0] to_bcd(input int mv);
        return {4'(mv / 1000), 4'((mv / 100) % 10), 4'((mv / 10) % 10), 4'(mv % 10)};
    endfunction

    always @(negedge clk) begin
        if (valid) begin
            valid_cnt++;
            $display("t=%0d valid ch=%0d mv=%0d bcd=%h", cyc, ch_out, mv_bin, mv_bcd);
            check("valid_single", {31'd0, prev_valid}, 32'd0);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got ch=%0d bcd=%h expected no pulse", ch_out, mv_bcd);
            end else begin
                mon_e = sb_q.pop_front();
                check("mv_bcd", {16'd0, mv_bcd}, {16'd0, mon_e.bcd});
                check("mv_bin", {20'd0, mv_bin}, {20'd0, mon_e.bin});
                check("ch_out", {29'd0, ch_out}, {29'd0, mon_e.ch});
                check("latency", cyc - mon_e.t_cap, 32'd14);
            end
        end
        if (valid2) valid2_cnt++;
        prev_valid = valid;
    end

    // One ADC frame: 3 busy cycles, then data with busy low; capture on the next edge.
    task automatic send_sample(input logic [11:0] d, input bit push, input logic [2:0] ch,
                               input logic [15:0] bcd, input logic [11:0] bin, input int tail);
        exp_t e;
        adc_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        adc_busy = 1'b0;
        adc_data = d;
        @(posedge clk);
        #1;
        if (push) begin
            e.bcd = bcd; e.bin = bin; e.ch = ch; e.t_cap = cyc;
            sb_q.push_back(e);
            n_expected++;
        end
        repeat (tail) @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [11:0] vals [16], input logic [2:0] ch,
                              input logic [15:0] bcd, input logic [11:0] bin,
                              input bit push, input int tail);
        addr = ch;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++)
            send_sample(vals[i], push && (i == 15), ch, bcd, bin, (i == 15) ? tail : 12);
    endtask

    task automatic fast_sample2(input logic [11:0] d);
        adc_busy2 = 1'b1;
        @(posedge clk);
        #1;
        adc_busy2 = 1'b0;
        adc_data2 = d;
        @(posedge clk);
        #1;
    endtask

    logic [11:0] vals [16];
    int          sum;
    logic [11:0] mv_exp;
    logic [2:0]  ch_r;

    initial begin
        rst = 1'b0;
        adc_busy = 1'b0; adc_data = '0; addr = '0;
        adc_busy2 = 1'b0; adc_data2 = '0; addr2 = '0;

        vecs[0] = '{12'hFFF, 12'hFFF, 3'd0, 16'h3299, 12'd3299};
        vecs[1] = '{12'h000, 12'h000, 3'd0, 16'h0000, 12'd0};
        vecs[2] = '{12'h800, 12'h800, 3'd0, 16'h1650, 12'd1650};
`ifdef ADC_AVG_ROUND_EN
        vecs[3] = '{12'd1000, 12'd1001, 3'd3, 16'h0806, 12'd806};
        vecs[4] = '{12'd1, 12'd0, 3'd7, 16'h0001, 12'd1};
        vecs[5] = '{12'd100, 12'd4000, 3'd6, 16'h1652, 12'd1652};
`else
        vecs[3] = '{12'd1000, 12'd1001, 3'd3, 16'h0805, 12'd805};
        vecs[4] = '{12'd1, 12'd0, 3'd7, 16'h0000, 12'd0};
        vecs[5] = '{12'd100, 12'd4000, 3'd6, 16'h1651, 12'd1651};
`endif

        repeat (3) @(posedge clk);
        #1;
        check("reset_mv_bcd", {16'd0, mv_bcd}, 32'd0);
        check("reset_mv_bin", {20'd0, mv_bin}, 32'd0);
        check("reset_ch_out", {29'd0, ch_out}, 32'd0);
        check("reset_valid", {31'd0, valid}, 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Overrun: second 2-sample window completes while the first is in CONV.
        fast_sample2(12'hFFF);
        fast_sample2(12'hFFF);
        fast_sample2(12'h000);
        fast_sample2(12'h000);
        repeat (25) @(posedge clk);
        #1;
        check("overrun_valid_count", valid2_cnt, 32'd1);
        check("overrun_mv_bcd", {16'd0, mv_bcd2}, 32'h3299);
        check("overrun_mv_bin", {20'd0, mv_bin2}, 32'd3299);
        fast_sample2(12'h800);
        fast_sample2(12'h800);
        repeat (20) @(posedge clk);
        #1;
        check("after_overrun_valid_count", valid2_cnt, 32'd2);
        check("after_overrun_mv_bcd", {16'd0, mv_bcd2}, 32'h1650);

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 16; j++) vals[j] = (j < 8) ? vecs[i].v1 : vecs[i].v2;
            run_window(vals, vecs[i].ch, vecs[i].bcd, vecs[i].bin, 1'b1, 12);
        end

        for (int r = 0; r < 3; r++) begin
            sum = 0;
            for (int j = 0; j < 16; j++) begin
                vals[j] = 12'($urandom_range(0, 4095));
                sum += int'(vals[j]);
            end
            mv_exp = model_mv(sum);
            ch_r = 3'($urandom_range(0, 7));
            run_window(vals, ch_r, to_bcd(int'(mv_exp)), mv_exp, 1'b1, 12);
        end

        // Channel change discards a 7-sample partial window.
        addr = 3'd2;
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 7; j++) send_sample(12'hFFF, 1'b0, 3'd2, 16'h0, 12'h0, 12);
        for (int j = 0; j < 16; j++) vals[j] = 12'h800;
        run_window(vals, 3'd5, 16'h1650, 12'd1650, 1'b1, 12);
        repeat (20) @(posedge clk);
        #1;

        // Reset mid-CONV: no result for that window, outputs cleared at once.
        for (int j = 0; j < 16; j++) vals[j] = 12'h400;
        run_window(vals, 3'd5, 16'h0, 12'h0, 1'b0, 5);
        rst = 1'b0;
        #1;
        check("abort_mv_bcd", {16'd0, mv_bcd}, 32'd0);
        check("abort_mv_bin", {20'd0, mv_bin}, 32'd0);
        check("abort_ch_out", {29'd0, ch_out}, 32'd0);
        check("abort_valid", {31'd0, valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("post_abort_mv_bcd", {16'd0, mv_bcd}, 32'd0);
        for (int j = 0; j < 16; j++) vals[j] = 12'hFFF;
        run_window(vals, 3'd4, 16'h3299, 12'd3299, 1'b1, 12);

        repeat (20) @(posedge clk);
        #1;
        check("pending_results", sb_q.size(), 32'd0);
        check("valid_total", valid_cnt, n_expected);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
